// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared encodings for the MMIO load/store unit: access
//                sizes, controller state encoding, channel-count ceiling.
//  Revision    : 1.0  initial release
// ============================================================================
package mmio_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // Largest number of slave channels the decoder supports
    localparam int CH_MAX = 8;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage : mmio_pkg
`default_nettype wire

// File: rtl/mmio_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_lane
//  Description : Byte-lane logic. Maps size + low address bits onto byte
//                enables, replicates store data across lanes and extracts /
//                extends load data. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_lane
    import mmio_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the returned word
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Size-dependent enables, write replication and read extension;
    // the reserved size never reaches the channel so it yields all zeros
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        o_rdata = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'h00_0000, w_byte}
                                     : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_unsigned ? {16'h0000, w_half}
                                     : {{16{w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = 32'h0000_0000;
                o_rdata = 32'h0000_0000;
            end
        endcase
    end

endmodule : mmio_lane
`default_nettype wire

// File: rtl/mmio_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_lsu
//  Description : Single-outstanding load/store unit. Decodes a request onto
//                one of NUM_CH memory-mapped channels, waits for that
//                channel's ack (bounded by TIMEOUT) and returns aligned,
//                extended read data with an error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_lsu
    import mmio_pkg::*;
#(
    parameter int                   NUM_CH  = 2,
    parameter logic [NUM_CH*32-1:0] CH_BASE = {32'h0003_2000, 32'h0000_0000},
    parameter logic [NUM_CH*32-1:0] CH_SIZE = {32'h0000_1000, 32'h0003_2000},
    parameter int                   TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [NUM_CH-1:0]    s_sel,
    output logic                 s_we,
    output logic [3:0]           s_be,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    input  logic [NUM_CH*32-1:0] s_rdata,
    input  logic [NUM_CH-1:0]    s_ack
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NUM_CH-1:0]   r_sel;
    logic                r_we;
    logic [1:0]          r_size;
    logic [1:0]          r_addr_lo;
    logic                r_unsigned;
    logic [31:0]         r_wdata;
    logic [31:0]         r_off;
    logic [CW-1:0]       r_cnt;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic [NUM_CH-1:0]   w_hit;
    logic [31:0]         w_off;
    logic                w_req_err;
    logic                w_accept;
    logic                w_ack;
    logic                w_tmo;
    logic [31:0]         w_rd_sel;
    logic [3:0]          w_be;
    logic [31:0]         w_wrep;
    logic [31:0]         w_rd_ext;
    logic                w_in_access;

    // Address decode: scanning from the top index down lets the lowest
    // overlapping channel overwrite any higher hit
    always_comb begin
        w_hit = '0;
        w_off = 32'h0000_0000;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((req_addr >= CH_BASE[32*i +: 32]) &&
                ((req_addr - CH_BASE[32*i +: 32]) < CH_SIZE[32*i +: 32])) begin
                w_hit    = '0;
                w_hit[i] = 1'b1;
                w_off    = req_addr - CH_BASE[32*i +: 32];
            end
        end
    end

    assign w_req_err = (w_hit == '0)
                     || (req_size == SZ_RSVD)
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_ack       = |(s_ack & r_sel);
    assign w_tmo       = (r_cnt == CW'(TIMEOUT - 1));

    // Read data from the selected channel only
    always_comb begin
        w_rd_sel = 32'h0000_0000;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_sel[i]) begin
                w_rd_sel = w_rd_sel | s_rdata[32*i +: 32];
            end
        end
    end

    mmio_lane u_lane (
        .i_size     (r_size),
        .i_addr_lo  (r_addr_lo),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (w_rd_sel),
        .o_be       (w_be),
        .o_wdata    (w_wrep),
        .o_rdata    (w_rd_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an ack beats a simultaneous timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = w_req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_ack || w_tmo) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_addr_lo  <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'h0000_0000;
            r_off      <= 32'h0000_0000;
            r_cnt      <= '0;
            r_rdata    <= 32'h0000_0000;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_sel      <= w_req_err ? '0 : w_hit;
            r_we       <= req_we;
            r_size     <= req_size;
            r_addr_lo  <= req_addr[1:0];
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_off      <= w_off;
            r_cnt      <= '0;
            r_rdata    <= 32'h0000_0000;
            r_err      <= w_req_err;
        end else if (w_in_access) begin
            if (w_ack) begin
                r_rdata <= r_we ? 32'h0000_0000 : w_rd_ext;
                r_err   <= 1'b0;
            end else if (w_tmo) begin
                r_rdata <= 32'h0000_0000;
                r_err   <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // Channel-side outputs are live only while an access is in flight
    assign s_sel     = w_in_access ? r_sel : '0;
    assign s_we      = w_in_access && r_we;
    assign s_be      = w_in_access ? w_be : 4'b0000;
    assign s_addr    = w_in_access ? r_off : 32'h0000_0000;
    assign s_wdata   = w_in_access ? w_wrep : 32'h0000_0000;

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = rsp_valid ? r_rdata : 32'h0000_0000;
    assign rsp_err   = rsp_valid && r_err;

endmodule : mmio_lsu
`default_nettype wire

// File: tb/tb_mmio_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_lsu
//  Description : Directed self-checking bench for mmio_lsu (default
//                two-channel map, TIMEOUT = 16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  s_sel;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [63:0] s_rdata;
    logic [1:0]  s_ack;

    int          n_tests;
    int          n_fail;

    logic [1:0]  snap_sel;
    logic        snap_we;
    logic [3:0]  snap_be;
    logic [31:0] snap_addr;
    logic [31:0] snap_wdata;
    logic [1:0]  ever_sel;

    mmio_lsu u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .s_sel        (s_sel),
        .s_we         (s_we),
        .s_be         (s_be),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_rdata      (s_rdata),
        .s_ack        (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request and let the DUT accept it on the next rising edge
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
    endtask

    // Drive acks cycle by cycle after acceptance; lat = cycle index where
    // rsp_valid first appears (0 if it never does within the bound)
    task automatic run_rsp(input logic [1:0] ack_mask, input int ack_cyc,
                           input logic [1:0] stray_mask, input int stray_cyc,
                           output int lat);
        bit done;
        lat      = 0;
        done     = 1'b0;
        ever_sel = 2'b00;
        for (int k = 1; k <= 40 && !done; k++) begin
            s_ack = ((k == ack_cyc) ? ack_mask : 2'b00) |
                    ((k == stray_cyc) ? stray_mask : 2'b00);
            @(negedge clk);
            ever_sel = ever_sel | s_sel;
            if (k == 1) begin
                snap_sel   = s_sel;
                snap_we    = s_we;
                snap_be    = s_be;
                snap_addr  = s_addr;
                snap_wdata = s_wdata;
            end
            if (rsp_valid) begin
                lat  = k;
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        s_ack = 2'b00;
    endtask

    // Full transaction with response checks; completes the handshake when
    // rsp_ready is high
    task automatic txn(input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] ack_mask, input int ack_cyc,
                       input logic [1:0] stray_mask, input int stray_cyc,
                       input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        do_req(we, sz, uns, addr, wdata);
        run_rsp(ack_mask, ack_cyc, stray_mask, stray_cyc, lat);
        check_eq({tag, ":lat"},   32'(lat),     32'(exp_lat));
        check_eq({tag, ":err"},   32'(rsp_err), 32'(exp_err));
        check_eq({tag, ":rdata"}, rsp_rdata,    exp_rdata);
        check_eq({tag, ":rsel0"}, 32'(s_sel),   32'd0);
        if (exp_err && exp_lat == 1) begin
            check_eq({tag, ":nosel"}, 32'(ever_sel), 32'd0);
        end
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b1;
        s_rdata      = 64'h0;
        s_ack        = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst:req_ready", 32'(req_ready), 32'd1);
        check_eq("rst:rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst:s_sel",     32'(s_sel),     32'd0);
        check_eq("rst:s_be",      32'(s_be),      32'd0);
        check_eq("rst:rsp_err",   32'(rsp_err),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Store byte, ch0, ack in first access cycle
        txn("sb", 1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5,
            2'b01, 1, 2'b00, 0, 2, 1'b0, 32'h0);
        check_eq("sb:sel",   32'(snap_sel), 32'h1);
        check_eq("sb:we",    32'(snap_we),  32'h1);
        check_eq("sb:be",    32'(snap_be),  32'h8);
        check_eq("sb:addr",  snap_addr,     32'h0000_0103);
        check_eq("sb:wdata", snap_wdata,    32'hA5A5_A5A5);

        // Signed / unsigned halfword load from upper half
        s_rdata = {32'h0, 32'h8001_1234};
        txn("lh", 1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0,
            2'b01, 1, 2'b00, 0, 2, 1'b0, 32'hFFFF_8001);
        check_eq("lh:be", 32'(snap_be), 32'hC);
        check_eq("lh:we", 32'(snap_we), 32'h0);
        txn("lhu", 1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0,
            2'b01, 1, 2'b00, 0, 2, 1'b0, 32'h0000_8001);

        // Word load from ch1 with ack in the fifth access cycle
        s_rdata = {32'hDEAD_BEEF, 32'h0};
        txn("lw1", 1'b0, 2'd2, 1'b0, 32'h0003_2004, 32'h0,
            2'b10, 5, 2'b00, 0, 6, 1'b0, 32'hDEAD_BEEF);
        check_eq("lw1:sel",  32'(snap_sel), 32'h2);
        check_eq("lw1:addr", snap_addr,     32'h4);
        check_eq("lw1:be",   32'(snap_be),  32'hF);

        // Signed byte load from ch1 lane 1
        s_rdata = {32'h1234_8056, 32'h0};
        txn("lb1", 1'b0, 2'd0, 1'b0, 32'h0003_2001, 32'h0,
            2'b10, 1, 2'b00, 0, 2, 1'b0, 32'hFFFF_FF80);
        check_eq("lb1:be",   32'(snap_be), 32'h2);
        check_eq("lb1:addr", snap_addr,    32'h1);

        // Store half to upper lanes
        txn("sh", 1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h1234_BEEF,
            2'b01, 1, 2'b00, 0, 2, 1'b0, 32'h0);
        check_eq("sh:be",    32'(snap_be), 32'hC);
        check_eq("sh:wdata", snap_wdata,   32'hBEEF_BEEF);

        // Region edges: last word of ch0, last word of ch1
        s_rdata = {32'h5555_AAAA, 32'h1111_2222};
        txn("edge0", 1'b0, 2'd2, 1'b0, 32'h0003_1FFC, 32'h0,
            2'b01, 1, 2'b00, 0, 2, 1'b0, 32'h1111_2222);
        check_eq("edge0:addr", snap_addr, 32'h0003_1FFC);
        txn("edge1", 1'b0, 2'd2, 1'b0, 32'h0003_2FFC, 32'h0,
            2'b10, 1, 2'b00, 0, 2, 1'b0, 32'h5555_AAAA);
        check_eq("edge1:addr", snap_addr, 32'h0000_0FFC);

        // Immediate errors
        txn("misw",  1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 2'b11, 1, 2'b00, 0, 1, 1'b1, 32'h0);
        txn("mish",  1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 2'b11, 1, 2'b00, 0, 1, 1'b1, 32'h0);
        txn("unmap", 1'b0, 2'd2, 1'b0, 32'h0004_0000, 32'h0, 2'b11, 1, 2'b00, 0, 1, 1'b1, 32'h0);
        txn("past1", 1'b1, 2'd0, 1'b0, 32'h0003_3000, 32'hFF, 2'b11, 1, 2'b00, 0, 1, 1'b1, 32'h0);
        txn("rsvd",  1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 2'b11, 1, 2'b00, 0, 1, 1'b1, 32'h0);

        // Timeout with a stray ack on the unselected channel
        s_rdata = {32'hFFFF_FFFF, 32'h7777_7777};
        txn("tmo", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,
            2'b00, 0, 2'b10, 3, 17, 1'b1, 32'h0);
        // Ack coinciding with the last wait cycle wins
        txn("tmoack", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,
            2'b01, 16, 2'b00, 0, 17, 1'b0, 32'h7777_7777);

        // Response back-pressure
        rsp_ready = 1'b0;
        s_rdata   = {32'h0, 32'hAB00_0000};
        txn("hold", 1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0,
            2'b01, 1, 2'b00, 0, 2, 1'b0, 32'h0000_00AB);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("hold:valid", 32'(rsp_valid), 32'd1);
            check_eq("hold:rdata", rsp_rdata,      32'h0000_00AB);
            check_eq("hold:ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rel:valid", 32'(rsp_valid), 32'd0);
        check_eq("rel:ready", 32'(req_ready), 32'd1);

        // Reset while an access is pending
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0);
        @(negedge clk);
        check_eq("rsta:sel", 32'(s_sel), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rsta:sel0",  32'(s_sel),     32'd0);
        check_eq("rsta:ready", 32'(req_ready), 32'd1);
        check_eq("rsta:valid", 32'(rsp_valid), 32'd0);
        ever_sel = 2'b00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            ever_sel = ever_sel | {1'b0, rsp_valid};
        end
        check_eq("rsta:norsp", 32'(ever_sel), 32'd0);

        // Normal operation after reset
        s_rdata = {32'h0, 32'hCAFE_F00D};
        txn("post", 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,
            2'b01, 2, 2'b00, 0, 3, 1'b0, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mmio_lsu
`default_nettype wire
